// File: rtl/cp0_timer_intc_if.sv
// Core-to-CP0 bundle: mfc0/mtc0 access, exception/eret commit, hw interrupt lines and CP0 status outputs.
// The master is the core side; the slave is the coprocessor.
interface cp0_timer_intc_if #(
    parameter int N_HW_INT = 5
);
    logic                mfc0;
    logic                mtc0;
    logic [4:0]          rd;
    logic [31:0]         wdata;
    logic [31:0]         pc;
    logic                exception;
    logic [4:0]          exc_code;
    logic                eret;
    logic [N_HW_INT-1:0] hw_int;
    logic [31:0]         rdata;
    logic [31:0]         status;
    logic                int_req;
    logic                timer_int;
    logic [31:0]         exc_addr;
    logic [31:0]         ret_addr;

    modport master (
        output mfc0, mtc0, rd, wdata, pc, exception, exc_code, eret, hw_int,
        input  rdata, status, int_req, timer_int, exc_addr, ret_addr
    );

    modport slave (
        input  mfc0, mtc0, rd, wdata, pc, exception, exc_code, eret, hw_int,
        output rdata, status, int_req, timer_int, exc_addr, ret_addr
    );
endinterface

// File: rtl/cp0_timer_intc.sv
// MIPS coprocessor 0: Count/Compare timer, interrupt sync+masking, exception entry and eret.
// Every register update takes one clk edge; mfc0 read data and int_req are combinational.
module cp0_timer_intc #(
    parameter int          N_HW_INT    = 5,
    parameter int          TIMER_DIV   = 1,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'h0040_0004,
    parameter logic [31:0] STATUS_RST  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    cp0_timer_intc_if.slave bus
);
    localparam logic [7:0] DIV_MAX = 8'(TIMER_DIV - 1);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [31:0]         r_count;
    logic [31:0]         r_compare;
    logic [31:0]         r_epc;
    logic [7:0]          r_div;
    logic                r_timer_int;
    logic                r_ie;
    logic                r_exl;
    logic [7:0]          r_im;
    logic [4:0]          r_exc_code;
    logic [1:0]          r_sw_ip;
    logic [N_HW_INT-1:0] r_sync [SYNC_STAGES];

    logic        w_tick;
    logic [31:0] w_count_inc;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [7:0]  w_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_rdata;

    assign w_tick      = (r_div == DIV_MAX);
    assign w_count_inc = r_count + 32'd1;

    assign w_wr_count   = bus.mtc0 && (bus.rd == REG_COUNT);
    assign w_wr_compare = bus.mtc0 && (bus.rd == REG_COMPARE);
    // exception and eret own Status/Cause/EPC for the cycle, so software writes to them are dropped
    assign w_wr_status  = bus.mtc0 && (bus.rd == REG_STATUS) && !bus.exception && !bus.eret;
    assign w_wr_cause   = bus.mtc0 && (bus.rd == REG_CAUSE)  && !bus.exception && !bus.eret;
    assign w_wr_epc     = bus.mtc0 && (bus.rd == REG_EPC)    && !bus.exception && !bus.eret;

    always_comb begin
        w_ip                = 8'd0;
        w_ip[1:0]           = r_sw_ip;
        w_ip[2 +: N_HW_INT] = r_sync[SYNC_STAGES-1];
        w_ip[7]             = r_timer_int;
    end

    assign w_status = {16'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {16'd0, w_ip, 1'b0, r_exc_code, 2'b00};

    always_comb begin
        w_rdata = 32'd0;
        if (bus.mfc0) begin
            case (bus.rd)
                REG_COUNT:   w_rdata = r_count;
                REG_COMPARE: w_rdata = r_compare;
                REG_STATUS:  w_rdata = w_status;
                REG_CAUSE:   w_rdata = w_cause;
                REG_EPC:     w_rdata = r_epc;
                default:     w_rdata = 32'd0;
            endcase
        end
    end

    // Timer: divider, Count and the sticky Count==Compare flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div       <= 8'd0;
            r_count     <= 32'd0;
            r_compare   <= 32'hFFFF_FFFF;
            r_timer_int <= 1'b0;
        end else begin
            r_div <= w_tick ? 8'd0 : r_div + 8'd1;
            if (w_wr_count) begin
                r_count <= bus.wdata;
            end else if (w_tick) begin
                r_count <= w_count_inc;
            end
            if (w_wr_compare) begin
                r_compare   <= bus.wdata;
                r_timer_int <= 1'b0;
            end else if (w_tick && !w_wr_count && (w_count_inc == r_compare)) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= bus.hw_int;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Status / Cause / EPC with exception > eret > mtc0 priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie       <= STATUS_RST[0];
            r_exl      <= STATUS_RST[1];
            r_im       <= STATUS_RST[15:8];
            r_exc_code <= 5'd0;
            r_sw_ip    <= 2'd0;
            r_epc      <= 32'd0;
        end else begin
            if (bus.exception) begin
                r_exl      <= 1'b1;
                r_exc_code <= bus.exc_code;
                r_epc      <= bus.pc;
            end else if (bus.eret) begin
                r_exl <= 1'b0;
            end
            if (w_wr_status) begin
                r_ie  <= bus.wdata[0];
                r_exl <= bus.wdata[1];
                r_im  <= bus.wdata[15:8];
            end
            if (w_wr_cause) begin
                r_sw_ip <= bus.wdata[9:8];
            end
            if (w_wr_epc) begin
                r_epc <= bus.wdata;
            end
        end
    end

    assign bus.rdata     = w_rdata;
    assign bus.status    = w_status;
    assign bus.int_req   = r_ie && !r_exl && |(w_ip & r_im);
    assign bus.timer_int = r_timer_int;
    assign bus.exc_addr  = EXC_VECTOR;
    assign bus.ret_addr  = r_epc;
endmodule

// File: tb/tb_cp0_timer_intc.sv
// Drives two CP0 configurations from one stimulus stream and checks them against a register-level model.
module tb_cp0_timer_intc;
    localparam logic [31:0] VEC_A = 32'h0040_0004;
    localparam logic [31:0] VEC_B = 32'h8000_0180;
    localparam logic [31:0] SRST_A = 32'h0000_0000;
    localparam logic [31:0] SRST_B = 32'hFFFF_FF03;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mfc0 = 0, mtc0 = 0, exception = 0, eret = 0;
    logic [4:0]  rd = 0, exc_code = 0;
    logic [31:0] wdata = 0, pc = 0;
    logic [4:0]  hw_int = 0;

    cp0_timer_intc_if #(.N_HW_INT(5)) ifa ();
    cp0_timer_intc_if #(.N_HW_INT(3)) ifb ();

    assign ifa.mfc0 = mfc0;      assign ifb.mfc0 = mfc0;
    assign ifa.mtc0 = mtc0;      assign ifb.mtc0 = mtc0;
    assign ifa.rd = rd;          assign ifb.rd = rd;
    assign ifa.wdata = wdata;    assign ifb.wdata = wdata;
    assign ifa.pc = pc;          assign ifb.pc = pc;
    assign ifa.exception = exception; assign ifb.exception = exception;
    assign ifa.exc_code = exc_code;   assign ifb.exc_code = exc_code;
    assign ifa.eret = eret;      assign ifb.eret = eret;
    assign ifa.hw_int = hw_int;  assign ifb.hw_int = hw_int[2:0];

    cp0_timer_intc #(.N_HW_INT(5), .TIMER_DIV(1), .SYNC_STAGES(2),
                     .EXC_VECTOR(VEC_A), .STATUS_RST(SRST_A))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    cp0_timer_intc #(.N_HW_INT(3), .TIMER_DIV(4), .SYNC_STAGES(3),
                     .EXC_VECTOR(VEC_B), .STATUS_RST(SRST_B))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0]     count;
        logic [31:0]     compare;
        logic [31:0]     epc;
        logic [31:0]     edges;   // clock edges since reset
        logic            ie;
        logic            exl;
        logic [7:0]      im;
        logic [4:0]      exc;
        logic [1:0]      sw;
        logic            tint;
        logic [2:0][4:0] hist;    // hist[k] = hw_int sampled k+1 edges ago
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t mreset(input logic [31:0] srst);
        mst_t s;
        s = '0;
        s.compare = 32'hFFFF_FFFF;
        s.ie = srst[0];
        s.exl = srst[1];
        s.im = srst[15:8];
        return s;
    endfunction

    function automatic mst_t mstep(input mst_t s, input int div);
        mst_t ns;
        logic [31:0] n;
        ns = s;
        n = s.edges + 1;
        ns.edges = n;
        if (mtc0 && rd == 9) ns.count = wdata;
        else if ((n % div) == 0) begin
            ns.count = s.count + 1;
            if (ns.count == s.compare) ns.tint = 1'b1;
        end
        if (mtc0 && rd == 11) begin
            ns.compare = wdata;
            ns.tint = 1'b0;
        end
        if (exception) begin
            ns.epc = pc; ns.exc = exc_code; ns.exl = 1'b1;
        end else if (eret) begin
            ns.exl = 1'b0;
        end else if (mtc0) begin
            if (rd == 12) begin ns.ie = wdata[0]; ns.exl = wdata[1]; ns.im = wdata[15:8]; end
            if (rd == 13) ns.sw = wdata[9:8];
            if (rd == 14) ns.epc = wdata;
        end
        ns.hist = {s.hist[1:0], hw_int};
        return ns;
    endfunction

    function automatic logic [7:0] m_ip(input mst_t s, input int nlines, input int sync);
        logic [4:0] mask;
        mask = 5'((1 << nlines) - 1);
        return {s.tint, s.hist[sync-1] & mask, s.sw};
    endfunction

    function automatic logic [31:0] m_status(input mst_t s);
        return {16'd0, s.im, 6'd0, s.exl, s.ie};
    endfunction

    function automatic logic [31:0] m_rdata(input mst_t s, input int nlines, input int sync);
        if (!mfc0) return 32'd0;
        case (rd)
            5'd9:  return s.count;
            5'd11: return s.compare;
            5'd12: return m_status(s);
            5'd13: return {16'd0, m_ip(s, nlines, sync), 1'b0, s.exc, 2'b00};
            5'd14: return s.epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_intreq(input mst_t s, input int nlines, input int sync);
        return {31'd0, s.ie & ~s.exl & (|(m_ip(s, nlines, sync) & s.im))};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mreset(SRST_A);
            mb <= mreset(SRST_B);
        end else begin
            ma <= mstep(ma, 1);
            mb <= mstep(mb, 4);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("A.rdata",     ifa.rdata,            m_rdata(ma, 5, 2));
            check("A.status",    ifa.status,           m_status(ma));
            check("A.int_req",   {31'd0, ifa.int_req}, m_intreq(ma, 5, 2));
            check("A.timer_int", {31'd0, ifa.timer_int}, {31'd0, ma.tint});
            check("A.exc_addr",  ifa.exc_addr,         VEC_A);
            check("A.ret_addr",  ifa.ret_addr,         ma.epc);
            check("B.rdata",     ifb.rdata,            m_rdata(mb, 3, 3));
            check("B.status",    ifb.status,           m_status(mb));
            check("B.int_req",   {31'd0, ifb.int_req}, m_intreq(mb, 3, 3));
            check("B.timer_int", {31'd0, ifb.timer_int}, {31'd0, mb.tint});
            check("B.exc_addr",  ifb.exc_addr,         VEC_B);
            check("B.ret_addr",  ifb.ret_addr,         mb.epc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        mtc0 = 1; rd = r; wdata = d;
        step();
    endtask

    task automatic rd_a(input string nm, input logic [4:0] r, input logic [31:0] exp);
        mfc0 = 1; rd = r;
        #1;
        check(nm, ifa.rdata, exp);
    endtask

    task automatic rd_b(input string nm, input logic [4:0] r, input logic [31:0] exp);
        mfc0 = 1; rd = r;
        #1;
        check(nm, ifb.rdata, exp);
    endtask

    logic [31:0] tmp;
    bit          seen;

    initial begin
        @(posedge clk);
        #1;
        check("rst.status", ifa.status, 32'h0);
        check("rst.timer_int", {31'd0, ifa.timer_int}, 32'h0);
        check("rst.int_req", {31'd0, ifa.int_req}, 32'h0);
        check("rst.ret_addr", ifa.ret_addr, 32'h0);
        rd_a("rst.compare", 5'd11, 32'hFFFF_FFFF);
        check("rstB.status", ifb.status, 32'h0000_FF03);
        @(posedge clk);
        #1;
        rst = 0; mfc0 = 0;
        chk_en = 1;

        // timer match raises timer_int and int_req as Count becomes 5
        wr(5'd9, 32'd0);
        wr(5'd11, 32'd5);
        wr(5'd12, 32'h0000_8001);
        rd_a("t1.count2", 5'd9, 32'd2);
        steps(2);
        check("t1.no_timer_yet", {31'd0, ifa.timer_int}, 32'h0);
        step();
        check("t1.timer_int", {31'd0, ifa.timer_int}, 32'h1);
        check("t1.int_req", {31'd0, ifa.int_req}, 32'h1);
        rd_a("t1.count5", 5'd9, 32'd5);

        // Compare write clears; clear wins over a same-cycle match
        wr(5'd11, 32'd20);
        check("t2.cleared", {31'd0, ifa.timer_int}, 32'h0);
        steps(13);
        rd_a("t2.count19", 5'd9, 32'd19);
        wr(5'd11, 32'd20);
        check("t2.clear_wins", {31'd0, ifa.timer_int}, 32'h0);
        rd_a("t2.count20", 5'd9, 32'd20);

        // synchronised hw interrupt, then interrupt entry
        wr(5'd12, 32'h0000_0401);
        hw_int = 5'b00001;
        step();
        check("t3.sync1", {31'd0, ifa.int_req}, 32'h0);
        step();
        check("t3.sync2", {31'd0, ifa.int_req}, 32'h1);
        exception = 1; exc_code = 5'd0; pc = 32'h0040_0100;
        step();
        check("t3.epc", ifa.ret_addr, 32'h0040_0100);
        check("t3.status", ifa.status, 32'h0000_0403);
        check("t3.int_req", {31'd0, ifa.int_req}, 32'h0);

        // nested syscall, then eret
        hw_int = 5'b0;
        exception = 1; exc_code = 5'd8; pc = 32'h0040_0020;
        step();
        mfc0 = 1; rd = 5'd13;
        #1;
        tmp = ifa.rdata;
        check("t4.exccode", {27'd0, tmp[6:2]}, 32'd8);
        check("t4.ret_addr", ifa.ret_addr, 32'h0040_0020);
        check("t4.exl_set", ifa.status, 32'h0000_0403);
        eret = 1;
        step();
        check("t4.exl_clr", ifa.status, 32'h0000_0401);
        check("t4.exc_addr", ifa.exc_addr, 32'h0040_0004);

        // exception beats eret and mtc0 Status in the same cycle
        exception = 1; exc_code = 5'd9; pc = 32'h0040_0200;
        eret = 1; mtc0 = 1; rd = 5'd12; wdata = 32'h0;
        step();
        check("t5.status", ifa.status, 32'h0000_0403);
        check("t5.epc", ifa.ret_addr, 32'h0040_0200);
        wr(5'd9, 32'h0000_1234);
        rd_a("t5.count_wr", 5'd9, 32'h0000_1234);

        // divide-by-4 Count and wrap through zero
        wr(5'd9, 32'hFFFF_FFFE);
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            mfc0 = 1; rd = 5'd9;
            #1;
            if (ifb.rdata == 32'hFFFF_FFFF) seen = 1;
            else step();
        end
        check("t6.first_tick", {31'd0, seen}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            rd_b("t6.hold", 5'd9, 32'hFFFF_FFFF);
        end
        step();
        rd_b("t6.wrap", 5'd9, 32'h0);

        // asynchronous reset mid-count
        steps(3);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        check("t6.rst_status", ifa.status, 32'h0);
        check("t6.rst_timer", {31'd0, ifa.timer_int}, 32'h0);
        check("t6.rst_ret", ifa.ret_addr, 32'h0);
        rd_a("t6.rst_countA", 5'd9, 32'h0);
        rd_b("t6.rst_countB", 5'd9, 32'h0);
        check("t6.rst_statusB", ifb.status, 32'h0000_FF03);
        @(posedge clk);
        #1;
        rst = 0; mfc0 = 0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mfc0 = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0: rd = 5'd9;
                1: rd = 5'd11;
                2: rd = 5'd12;
                3: rd = 5'd13;
                4: rd = 5'd14;
                5: rd = 5'($urandom);
                default: rd = 5'd9;
            endcase
            mtc0  = ($urandom_range(0, 3) == 0);
            wdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            pc    = $urandom;
            exception = ($urandom_range(0, 15) == 0);
            exc_code  = 5'($urandom);
            eret      = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) hw_int = 5'($urandom);
            if ($urandom_range(0, 699) == 0) begin
                #2;
                rst = 1;
                @(posedge clk);
                #1;
                rst = 0;
                mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
